poly_io_regs: RTL and testbench
===============================

POLY_IO_REGS -- requirements
Module: POLY_io_regs

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 17: width of one BRAM word / DSP operand.
REQ-002 SHALL have parameter N, default 5: coefficients per AMNS polynomial.
REQ-003 SHALL have parameter S, default 4: WORD_WIDTH blocks per coefficient. Define L = N*S and PW = L*WORD_WIDTH.
REQ-004 SHALL have port clock_i  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port BRAM_dout_i  input  WORD_WIDTH: word read from the operand BRAM.
REQ-007 SHALL have port INPUT_reg_sel_i  input  2: target register, 00=A, 01=B, 10=M, 11=M_prime_0.
REQ-008 SHALL have port INPUT_reg_en_i  input  1: shift BRAM_dout_i into the selected register this cycle.
REQ-009 SHALL have port clear_i  input  1: synchronous clear of all fill counters and full flags.
REQ-010 SHALL have port RES_load_i  input  1: parallel-load RES_data_i into the result register.
REQ-011 SHALL have port RES_data_i  input  PW: result polynomial from the multiplier.
REQ-012 SHALL have port RES_reg_shift_i  input  1: advance the result register by one word.
REQ-013 SHALL have ports A_o, B_o, M_o  output  PW each: assembled operands; word k at bits [(k+1)*WORD_WIDTH-1 : k*WORD_WIDTH].
REQ-014 SHALL have port M_prime_0_o  output  N*WORD_WIDTH: assembled M'0 (N words).
REQ-015 SHALL have port full_o  output  4: per-register full flags, bit0=A, bit1=B, bit2=M, bit3=M_prime_0.
REQ-016 SHALL have port operands_ready_o  output  1: high when full_o == 4'b1111.
REQ-017 SHALL have port BRAM_din_o  output  WORD_WIDTH: current lowest word of the result register.
REQ-018 SHALL have port RES_empty_o  output  1: high when no result words remain to be stored.

Function
REQ-019 Input shift: when INPUT_reg_en_i=1, the selected register SHALL shift right by WORD_WIDTH and load BRAM_dout_i into its top word; the other registers hold.
REQ-020 After exactly L shifts (N for M_prime_0), the first-shifted word SHALL sit in word 0 and the last-shifted word in word L-1 (N-1).
REQ-021 Each register SHALL have a fill counter of width $clog2(L)+1 that increments per shift and saturates at L (N for M_prime_0).
REQ-022 Each full bit SHALL go high in the cycle after the counter reaches its limit and stay high until clear_i or reset.
REQ-023 Shifts beyond the limit SHALL still shift data (oldest word dropped) and SHALL leave the counter saturated and full set.
REQ-024 clear_i SHALL zero all counters and full_o on the next edge and SHALL NOT alter operand data; with clear_i and INPUT_reg_en_i both high, the shift SHALL occur and the counter SHALL end at 0.
REQ-025 Result register: RES_load_i SHALL capture RES_data_i and set the remaining-word counter to L; RES_empty_o SHALL then be 0.
REQ-026 With RES_reg_shift_i=1 and remaining>0, the register SHALL shift right one word, fill the top word with zero and decrement remaining; BRAM_din_o SHALL present word 0 combinationally from the register (zero latency).
REQ-027 With remaining=0, RES_reg_shift_i SHALL be ignored and BRAM_din_o SHALL hold 0.
REQ-028 When RES_load_i and RES_reg_shift_i are both high, the load SHALL win and the shift SHALL be discarded.
REQ-029 Input path and result path SHALL operate independently and concurrently.

Reset
REQ-030 While reset_i=0, all registers, counters and flags SHALL be 0 asynchronously: A_o=B_o=M_o=0, M_prime_0_o=0, full_o=0, operands_ready_o=0, BRAM_din_o=0, RES_empty_o=1.
REQ-031 Reset asserted mid-load or mid-store SHALL abort the operation, with no partial state kept after release.

Verification
REQ-032 N=5, S=4: 20 cycles with en=1, sel=00, BRAM_dout_i=1..20 -> A_o word k = k+1; full_o[0] rises the cycle after the 20th shift; B_o, M_o and M_prime_0_o stay 0.
REQ-033 Load B, M (20 words each) and M'0 (5 words, values 0x10..0x14) -> M_prime_0_o words = 0x10..0x14; operands_ready_o=1 exactly one cycle after the last shift.
REQ-034 21st A shift with value 0x55 -> A word 19 = 0x55, word 0 = 2; full_o[0] stays 1; then clear_i -> full_o=0 while A_o is unchanged.
REQ-035 RES_load_i with word k = 100+k, then 20 shift cycles -> BRAM_din_o = 100..119 in order; RES_empty_o=1 after the 20th shift; a 21st shift leaves BRAM_din_o=0.
REQ-036 RES_load_i and RES_reg_shift_i both high -> BRAM_din_o = new word 0 and remaining=20; reset_i pulsed low after 7 A shifts -> all outputs at reset values and counters at 0.

Source files
------------

// File: rtl/poly_io_regs.sv
// Operand input shift registers (A, B, M, M'0) with fill tracking, plus the result
// register that streams a finished polynomial back to BRAM one word at a time.
module poly_io_regs #(
    parameter int unsigned WORD_WIDTH = 17,
    parameter int unsigned N          = 5,
    parameter int unsigned S          = 4
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic [WORD_WIDTH-1:0]             BRAM_dout_i,
    input  logic [1:0]                        INPUT_reg_sel_i,
    input  logic                              INPUT_reg_en_i,
    input  logic                              clear_i,
    input  logic                              RES_load_i,
    input  logic [N*S*WORD_WIDTH-1:0]         RES_data_i,
    input  logic                              RES_reg_shift_i,
    output logic [N*S*WORD_WIDTH-1:0]         A_o,
    output logic [N*S*WORD_WIDTH-1:0]         B_o,
    output logic [N*S*WORD_WIDTH-1:0]         M_o,
    output logic [N*WORD_WIDTH-1:0]           M_prime_0_o,
    output logic [3:0]                        full_o,
    output logic                              operands_ready_o,
    output logic [WORD_WIDTH-1:0]             BRAM_din_o,
    output logic                              RES_empty_o
);

    localparam int unsigned L   = N * S;
    localparam int unsigned PW  = L * WORD_WIDTH;
    localparam int unsigned MPW = N * WORD_WIDTH;
    localparam int unsigned CW  = $clog2(L) + 1;

    localparam logic [CW-1:0] LIM_L = CW'(L);
    localparam logic [CW-1:0] LIM_N = CW'(N);

    logic [PW-1:0]           a_q, a_d, b_q, b_d, m_q, m_d;
    logic [MPW-1:0]          mp_q, mp_d;
    logic [3:0][CW-1:0]      cnt_q, cnt_d;
    logic [3:0]              full_q, full_d;
    logic [PW-1:0]           res_q, res_d;
    logic [CW-1:0]           rem_q, rem_d;
    logic [3:0]              sel_hit;
    logic [CW-1:0]           lim;

    always_comb begin
        sel_hit = INPUT_reg_en_i ? (4'b0001 << INPUT_reg_sel_i) : 4'b0000;

        // New words enter at the top so the first word written ends up in word 0.
        a_d  = sel_hit[0] ? {BRAM_dout_i, a_q[PW-1:WORD_WIDTH]}   : a_q;
        b_d  = sel_hit[1] ? {BRAM_dout_i, b_q[PW-1:WORD_WIDTH]}   : b_q;
        m_d  = sel_hit[2] ? {BRAM_dout_i, m_q[PW-1:WORD_WIDTH]}   : m_q;
        mp_d = sel_hit[3] ? {BRAM_dout_i, mp_q[MPW-1:WORD_WIDTH]} : mp_q;

        cnt_d  = cnt_q;
        full_d = full_q;
        lim    = LIM_L;
        for (int i = 0; i < 4; i++) begin
            lim = (i == 3) ? LIM_N : LIM_L;
            if (sel_hit[i] && (cnt_q[i] != lim)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            // Full follows the counter by one cycle.
            full_d[i] = full_q[i] | (cnt_q[i] == lim);
        end
        if (clear_i) begin
            cnt_d  = '0;
            full_d = '0;
        end

        res_d = res_q;
        rem_d = rem_q;
        if (RES_load_i) begin
            res_d = RES_data_i;
            rem_d = LIM_L;
        end else if (RES_reg_shift_i && (rem_q != '0)) begin
            res_d = {{WORD_WIDTH{1'b0}}, res_q[PW-1:WORD_WIDTH]};
            rem_d = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            mp_q   <= '0;
            cnt_q  <= '0;
            full_q <= '0;
            res_q  <= '0;
            rem_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            m_q    <= m_d;
            mp_q   <= mp_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            res_q  <= res_d;
            rem_q  <= rem_d;
        end
    end

    assign A_o              = a_q;
    assign B_o              = b_q;
    assign M_o              = m_q;
    assign M_prime_0_o      = mp_q;
    assign full_o           = full_q;
    assign operands_ready_o = &full_q;
    assign BRAM_din_o       = (rem_q != '0) ? res_q[WORD_WIDTH-1:0] : '0;
    assign RES_empty_o      = (rem_q == '0);

endmodule

// File: tb/tb_poly_io_regs.sv
// Self-checking bench for poly_io_regs: directed sequences, a result-path vector table and
// randomized traffic, all compared against a word-queue reference model.
module tb_poly_io_regs;

    localparam int W  = 17;
    localparam int N  = 5;
    localparam int S  = 4;
    localparam int L  = N * S;
    localparam int PW = L * W;
    localparam int MW = N * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  dout;
    logic [1:0]    sel;
    logic          en, clr, res_load, res_shift;
    logic [PW-1:0] res_data;
    logic [PW-1:0] a, b, m;
    logic [MW-1:0] mp;
    logic [3:0]    full;
    logic          ready, empty;
    logic [W-1:0]  din;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    poly_io_regs #(.WORD_WIDTH(W), .N(N), .S(S)) dut (
        .clock_i          (clk),
        .reset_i          (rst_n),
        .BRAM_dout_i      (dout),
        .INPUT_reg_sel_i  (sel),
        .INPUT_reg_en_i   (en),
        .clear_i          (clr),
        .RES_load_i       (res_load),
        .RES_data_i       (res_data),
        .RES_reg_shift_i  (res_shift),
        .A_o              (a),
        .B_o              (b),
        .M_o              (m),
        .M_prime_0_o      (mp),
        .full_o           (full),
        .operands_ready_o (ready),
        .BRAM_din_o       (din),
        .RES_empty_o      (empty)
    );

    // Reference model: each operand is the last 'limit' words written (zero padded),
    // the result is a queue of words still to be stored.
    logic [W-1:0] mq[4][$];
    logic [W-1:0] rq[$];
    int           mcnt[4];
    bit           mfull[4];

    function automatic int lim(input int r);
        return (r == 3) ? N : L;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 4; r++) begin
            mq[r] = {};
            for (int k = 0; k < lim(r); k++) mq[r].push_back('0);
            mcnt[r]  = 0;
            mfull[r] = 1'b0;
        end
        rq = {};
    endtask

    task automatic model_edge();
        bit nf[4];
        for (int r = 0; r < 4; r++) nf[r] = !clr && (mfull[r] || (mcnt[r] == lim(r)));
        if (en) begin
            int r;
            r = int'(sel);
            mq[r].push_back(dout);
            void'(mq[r].pop_front());
            if (mcnt[r] < lim(r)) mcnt[r]++;
        end
        if (clr) for (int r = 0; r < 4; r++) mcnt[r] = 0;
        for (int r = 0; r < 4; r++) mfull[r] = nf[r];
        if (res_load) begin
            rq = {};
            for (int k = 0; k < L; k++) rq.push_back(res_data[k*W +: W]);
        end else if (res_shift && (rq.size() > 0)) begin
            void'(rq.pop_front());
        end
    endtask

    function automatic logic [PW-1:0] model_vec(input int r);
        logic [PW-1:0] v;
        v = '0;
        for (int k = 0; k < mq[r].size(); k++) v[k*W +: W] = mq[r][k];
        return v;
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [3:0]   ef;
        logic [W-1:0] ed;
        ef = {mfull[3], mfull[2], mfull[1], mfull[0]};
        ed = (rq.size() > 0) ? rq[0] : '0;
        chk("A_o", a, model_vec(0));
        chk("B_o", b, model_vec(1));
        chk("M_o", m, model_vec(2));
        chk("M_prime_0_o", PW'(mp), model_vec(3));
        chk("full_o", PW'(full), PW'(ef));
        chk("operands_ready_o", PW'(ready), PW'(&ef));
        chk("BRAM_din_o", PW'(din), PW'(ed));
        chk("RES_empty_o", PW'(empty), PW'(rq.size() == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        en = 1'b0; clr = 1'b0; res_load = 1'b0; res_shift = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic rand_res();
        for (int k = 0; k < L; k++) res_data[k*W +: W] = W'($urandom);
    endtask

    typedef struct {
        logic         load;
        logic         shift;
        logic [W-1:0] exp_din;
        logic         exp_empty;
    } res_vec_t;

    res_vec_t      tv[5];
    logic [PW-1:0] exp_v;
    logic [PW-1:0] saved;

    initial begin
        tv[0] = '{1'b1, 1'b0, 17'd100, 1'b0};
        tv[1] = '{1'b0, 1'b1, 17'd101, 1'b0};
        tv[2] = '{1'b0, 1'b0, 17'd101, 1'b0};
        tv[3] = '{1'b0, 1'b1, 17'd102, 1'b0};
        tv[4] = '{1'b1, 1'b1, 17'd100, 1'b0};

        rst_n = 1'b1; dout = '0; sel = '0; en = 1'b0; clr = 1'b0;
        res_load = 1'b0; res_shift = 1'b0; res_data = '0;
        #1;
        apply_reset();

        // Fill A with 1..20.
        sel = 2'd0; en = 1'b1;
        for (int i = 1; i <= L; i++) begin
            dout = W'(i);
            tick();
        end
        exp_v = '0;
        for (int k = 0; k < L; k++) exp_v[k*W +: W] = W'(k + 1);
        chk("A_fill_words", a, exp_v);
        chk("full0_same_cycle", PW'(full[0]), PW'(1'b0));
        en = 1'b0;
        tick();
        chk("full0_next_cycle", PW'(full[0]), PW'(1'b1));
        chk("B_untouched", b, '0);
        chk("M_untouched", m, '0);
        chk("MP_untouched", PW'(mp), '0);

        // Fill B, M, then M'0 with 0x10..0x14.
        en = 1'b1;
        sel = 2'd1;
        for (int i = 0; i < L; i++) begin dout = W'(200 + i); tick(); end
        sel = 2'd2;
        for (int i = 0; i < L; i++) begin dout = W'(300 + i); tick(); end
        sel = 2'd3;
        for (int i = 0; i < N; i++) begin dout = W'(16 + i); tick(); end
        chk("ready_same_cycle", PW'(ready), PW'(1'b0));
        en = 1'b0;
        tick();
        chk("ready_next_cycle", PW'(ready), PW'(1'b1));
        exp_v = '0;
        for (int k = 0; k < N; k++) exp_v[k*W +: W] = W'(16 + k);
        chk("MP_words", PW'(mp), exp_v);

        // Overflow shift then clear.
        sel = 2'd0; en = 1'b1; dout = 17'h55;
        tick();
        en = 1'b0;
        chk("A_word19_overflow", PW'(a[19*W +: W]), PW'(17'h55));
        chk("A_word0_overflow", PW'(a[0 +: W]), PW'(17'd2));
        chk("full0_stays", PW'(full[0]), PW'(1'b1));
        saved = a;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("full_cleared", PW'(full), '0);
        chk("A_kept_on_clear", a, saved);

        // Clear together with a shift: shift happens, counter restarts.
        sel = 2'd1; en = 1'b1; clr = 1'b1; dout = 17'h1abc;
        tick();
        en = 1'b0; clr = 1'b0;
        tick();

        // Result path table, words 100+k.
        for (int k = 0; k < L; k++) res_data[k*W +: W] = W'(100 + k);
        for (int i = 0; i < 5; i++) begin
            res_load = tv[i].load; res_shift = tv[i].shift;
            tick();
            chk($sformatf("tv%0d_din", i), PW'(din), PW'(tv[i].exp_din));
            chk($sformatf("tv%0d_empty", i), PW'(empty), PW'(tv[i].exp_empty));
        end
        res_load = 1'b0; res_shift = 1'b1;
        for (int k = 0; k < L; k++) begin
            chk("stream_din", PW'(din), PW'(100 + k));
            chk("stream_not_empty", PW'(empty), PW'(1'b0));
            tick();
        end
        chk("stream_empty", PW'(empty), PW'(1'b1));
        chk("stream_din_zero", PW'(din), '0);
        tick();
        chk("extra_shift_din", PW'(din), '0);
        res_shift = 1'b0;

        // Reset mid-load and mid-store.
        res_load = 1'b1; tick(); res_load = 1'b0; res_shift = 1'b1;
        sel = 2'd0; en = 1'b1;
        for (int i = 0; i < 7; i++) begin dout = W'(i + 40); tick(); end
        apply_reset();
        chk("rst_A", a, '0);
        chk("rst_full", PW'(full), '0);
        chk("rst_empty", PW'(empty), PW'(1'b1));
        chk("rst_din", PW'(din), '0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            sel       = 2'($urandom_range(0, 3));
            en        = 1'($urandom_range(0, 1));
            dout      = W'($urandom);
            clr       = ($urandom_range(0, 15) == 0);
            res_load  = ($urandom_range(0, 19) == 0);
            res_shift = 1'($urandom_range(0, 1));
            if (res_load) rand_res();
            if ($urandom_range(0, 299) == 0) apply_reset();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
